// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory load arbiter: FSM encoding,
// the default load terminator and the NOP returned while the CPU is stalled.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

   function automatic logic is_busy(input state_e s);
      return (s == ST_LOAD) || (s == ST_WRITE);
   endfunction

endpackage

// File: rtl/imem_load_arbiter_if.sv
// Bus bundle between the load arbiter, the UART receiver, the CPU fetch port
// and the external instruction RAM.
interface imem_load_arbiter_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
);
   logic                      i_load_start;
   logic [DATA_WIDTH-1:0]     i_rx_byte;
   logic                      i_rx_valid;
   logic [ADDR_WIDTH-1:0]     i_cpu_addr;
   logic [DATA_WIDTH*4-1:0]   o_cpu_instr;
   logic                      o_cpu_stall;
   logic                      o_ram_we;
   logic [ADDR_WIDTH-1:0]     o_ram_addr;
   logic [DATA_WIDTH*4-1:0]   o_ram_wdata;
   logic [DATA_WIDTH*4-1:0]   i_ram_rdata;
   logic                      o_busy;
   logic                      o_load_done;
   logic [ADDR_WIDTH-2:0]     o_word_count;

   modport slave (
      input  i_load_start, i_rx_byte, i_rx_valid, i_cpu_addr, i_ram_rdata,
      output o_cpu_instr, o_cpu_stall, o_ram_we, o_ram_addr, o_ram_wdata,
             o_busy, o_load_done, o_word_count
   );

   modport master (
      output i_load_start, i_rx_byte, i_rx_valid, i_cpu_addr, i_ram_rdata,
      input  o_cpu_instr, o_cpu_stall, o_ram_we, o_ram_addr, o_ram_wdata,
             o_busy, o_load_done, o_word_count
   );
endinterface

// File: rtl/byte_to_word_packer.sv
// Big-endian byte-to-word assembler: the first byte of a word ends up in the
// most significant lane. o_word_valid flags the cycle the fourth byte arrives.
module byte_to_word_packer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_clear,
   input  logic [DATA_WIDTH-1:0]   i_byte,
   input  logic                    i_valid,
   output logic [DATA_WIDTH*4-1:0] o_word,
   output logic                    o_word_valid
);
   logic [DATA_WIDTH*4-1:0] shift_q, shift_d;
   logic [1:0]              idx_q, idx_d;

   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      if (i_clear) begin
         shift_d = {(DATA_WIDTH*4){1'b0}};
         idx_d   = 2'd0;
      end else if (i_valid) begin
         shift_d = {shift_q[DATA_WIDTH*3-1:0], i_byte};
         idx_d   = idx_q + 2'd1;
      end else begin
         shift_d = shift_q;
         idx_d   = idx_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         shift_q <= {(DATA_WIDTH*4){1'b0}};
         idx_q   <= 2'd0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

   assign o_word       = shift_q;
   assign o_word_valid = i_valid && !i_clear && (idx_q == 2'd3);

endmodule

// File: rtl/imem_load_arbiter.sv
// Shares one instruction RAM between CPU fetches and a UART program loader;
// the CPU is stalled with NOPs while a load is writing the RAM.
module imem_load_arbiter
   import imem_pkg::*;
#(
   parameter int                      ADDR_WIDTH = 12,
   parameter int                      DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH*4-1:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   imem_load_arbiter_if.slave   bus
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ~ADDR_WIDTH'(3);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
   logic [ADDR_WIDTH-2:0]   wcnt_q, wcnt_d;
   logic                    last_word_s;
   logic                    pk_clear_s;
   logic                    pk_valid_s;
   logic                    pk_word_valid_s;
   logic [DATA_WIDTH*4-1:0] pk_word_s;

   byte_to_word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (pk_clear_s),
      .i_byte       (bus.i_rx_byte),
      .i_valid      (pk_valid_s),
      .o_word       (pk_word_s),
      .o_word_valid (pk_word_valid_s)
   );

   assign last_word_s = (pk_word_s == HALT_WORD) || (wptr_q == LAST_ADDR);
   // A byte arriving in the terminating WRITE cycle must not leak into the packer.
   assign pk_valid_s  = bus.i_rx_valid &&
                        ((state_q == ST_LOAD) || ((state_q == ST_WRITE) && !last_word_s));

   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      wcnt_d     = wcnt_q;
      pk_clear_s = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.i_load_start) begin
               state_d    = ST_LOAD;
               wptr_d     = {ADDR_WIDTH{1'b0}};
               wcnt_d     = {(ADDR_WIDTH-1){1'b0}};
               pk_clear_s = 1'b1;
            end else begin
               state_d    = state_q;
            end
         end
         ST_LOAD: begin
            if (pk_word_valid_s) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_WRITE: begin
            wptr_d  = wptr_q + ADDR_WIDTH'(4);
            wcnt_d  = wcnt_q + (ADDR_WIDTH-1)'(1);
            state_d = last_word_s ? ST_DONE : ST_LOAD;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         wptr_q  <= {ADDR_WIDTH{1'b0}};
         wcnt_q  <= {(ADDR_WIDTH-1){1'b0}};
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign bus.o_busy       = is_busy(state_q);
   assign bus.o_load_done  = (state_q == ST_DONE);
   assign bus.o_cpu_stall  = is_busy(state_q);
   assign bus.o_ram_we     = (state_q == ST_WRITE);
   assign bus.o_ram_addr   = is_busy(state_q) ? wptr_q : bus.i_cpu_addr;
   assign bus.o_ram_wdata  = pk_word_s;
   assign bus.o_cpu_instr  = is_busy(state_q) ? NOP_INSTR : bus.i_ram_rdata;
   assign bus.o_word_count = wcnt_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Randomized bench for imem_load_arbiter with a stream-level reference model
// and a behavioural RAM attached to the RAM port.
module tb_imem_load_arbiter;
   localparam int          AW   = 12;
   localparam int          DW   = 8;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   bit   cpu_chk  = 1'b0;

   logic [31:0] mem [0:1023];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [7:0]  stream[$];

   imem_load_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   imem_load_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HALT_WORD(HALT)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   assign bus.i_ram_rdata = mem[bus.o_ram_addr[11:2]];

   always @(posedge clk) begin
      if (bus.o_ram_we === 1'b1) begin
         wr_addr.push_back(32'(bus.o_ram_addr));
         wr_data.push_back(bus.o_ram_wdata);
         mem[bus.o_ram_addr[11:2]] = bus.o_ram_wdata;
      end
   end

   // Reference: group the byte stream big-endian into words at 4*i, stopping
   // after the halt word or after the last word of the address space.
   task automatic build_expect();
      logic [31:0] w;
      int          n;
      bit          stop;
      w = 32'h0; n = 0; stop = 1'b0;
      exp_addr.delete(); exp_data.delete();
      for (int i = 0; i < stream.size() && !stop; i++) begin
         w = {w[23:0], stream[i]};
         n++;
         if (n == 4) begin
            exp_addr.push_back(32'(exp_data.size() * 4));
            exp_data.push_back(w);
            n = 0;
            if (w == HALT || exp_data.size() == 1024) stop = 1'b1;
         end
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      stream.push_back(w[31:24]);
      stream.push_back(w[23:16]);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      return w;
   endfunction

   task automatic step();
      @(negedge clk);
      if (cpu_chk && !(wr_data.size() > 0 && wr_data[$] == HALT)) begin
         checks++;
         if (bus.o_cpu_stall !== 1'b1 || bus.o_cpu_instr !== 32'h0 ||
             bus.o_ram_addr !== 12'(wr_data.size() * 4)) begin
            failures++;
            $display("FAIL cpu_during_load: stall=%0b instr=%h ram_addr=%h, expected stall=1 instr=00000000 ram_addr=%h",
                     bus.o_cpu_stall, bus.o_cpu_instr, bus.o_ram_addr, 12'(wr_data.size() * 4));
         end
         bus.i_cpu_addr = bus.i_cpu_addr ^ 12'h004;
      end
   endtask

   task automatic start_load();
      wr_addr.delete(); wr_data.delete();
      bus.i_load_start = 1'b1;
      step();
      bus.i_load_start = 1'b0;
   endtask

   task automatic send_stream(input int first, input int last, input int max_gap);
      for (int i = first; i <= last; i++) begin
         bus.i_rx_byte  = stream[i];
         bus.i_rx_valid = 1'b1;
         step();
         bus.i_rx_valid = 1'b0;
         repeat ($urandom_range(0, max_gap)) step();
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (bus.o_load_done !== 1'b1 && n < 20000) begin
         step();
         n++;
      end
      checks++;
      if (bus.o_load_done !== 1'b1) begin
         failures++;
         $display("FAIL done_timeout: load_done=%0b after %0d cycles, expected 1", bus.o_load_done, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_cpu_addr = 12'h010;
      step(); step();
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_load_done !== 1'b0 || bus.o_ram_we !== 1'b0 ||
          bus.o_cpu_stall !== 1'b0 || bus.o_word_count !== 11'd0) begin
         failures++;
         $display("FAIL reset_values: busy=%0b done=%0b we=%0b stall=%0b count=%0d, expected all 0",
                  bus.o_busy, bus.o_load_done, bus.o_ram_we, bus.o_cpu_stall, bus.o_word_count);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.o_ram_addr !== 12'h010 || bus.o_cpu_instr !== 32'hA5A5_0004) begin
         failures++;
         $display("FAIL idle_passthrough: ram_addr=%h instr=%h, expected 010 a5a50004",
                  bus.o_ram_addr, bus.o_cpu_instr);
      end
   endtask

   task automatic test_basic();
      stream.delete();
      push_word(32'h1234_5678); push_word(HALT);
      start_load();
      send_stream(0, stream.size() - 1, 0);
      wait_done();
      checks++;
      if (wr_data.size() != 2) begin
         failures++;
         $display("FAIL basic_write_count: got %0d writes, expected 2", wr_data.size());
      end else begin
         checks++;
         if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h1234_5678 ||
             wr_addr[1] !== 32'h4 || wr_data[1] !== HALT) begin
            failures++;
            $display("FAIL basic_writes: %h@%h %h@%h, expected 12345678@000 ffffffff@004",
                     wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
         end
      end
      bus.i_cpu_addr = 12'h000;
      #1;
      checks++;
      if (bus.o_word_count !== 11'd2 || bus.o_cpu_instr !== 32'h1234_5678 || bus.o_cpu_stall !== 1'b0) begin
         failures++;
         $display("FAIL basic_readback: count=%0d instr=%h stall=%0b, expected 2 12345678 0",
                  bus.o_word_count, bus.o_cpu_instr, bus.o_cpu_stall);
      end
   endtask

   task automatic test_back_to_back();
      stream.delete();
      push_word(32'h0102_0304); push_word(32'hAABB_CCDD); push_word(HALT);
      start_load();
      send_stream(0, stream.size() - 1, 0);
      wait_done();
      checks++;
      if (wr_data.size() != 3) begin
         failures++;
         $display("FAIL b2b_write_count: got %0d writes, expected 3", wr_data.size());
      end else begin
         checks++;
         if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'hAABB_CCDD || wr_data[0] !== 32'h0102_0304) begin
            failures++;
            $display("FAIL b2b_second_word: %h@%h (first %h), expected aabbccdd@004 (first 01020304)",
                     wr_data[1], wr_addr[1], wr_data[0]);
         end
      end
   endtask

   task automatic test_ignored();
      logic [31:0] w;
      w = rand_word();
      stream.delete();
      push_word(w); push_word(HALT);
      start_load();
      send_stream(0, 1, 1);
      bus.i_load_start = 1'b1;
      step();
      bus.i_load_start = 1'b0;
      send_stream(2, stream.size() - 1, 1);
      wait_done();
      checks++;
      if (wr_data.size() != 2 || bus.o_word_count !== 11'd2) begin
         failures++;
         $display("FAIL ignore_start_count: writes=%0d count=%0d, expected 2 2", wr_data.size(), bus.o_word_count);
      end else begin
         checks++;
         if (wr_data[0] !== w || wr_addr[0] !== 32'h0) begin
            failures++;
            $display("FAIL ignore_start_word: %h@%h, expected %h@000", wr_data[0], wr_addr[0], w);
         end
      end
      stream.delete();
      push_word(rand_word()); push_word(HALT);
      send_stream(0, stream.size() - 1, 0);
      step(); step();
      checks++;
      if (wr_data.size() != 2 || bus.o_word_count !== 11'd2 || bus.o_load_done !== 1'b1 || bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL ignore_rx_in_done: writes=%0d count=%0d done=%0b busy=%0b, expected 2 2 1 0",
                  wr_data.size(), bus.o_word_count, bus.o_load_done, bus.o_busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      stream.delete();
      push_word(rand_word());
      start_load();
      send_stream(0, 1, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_load_done !== 1'b0 || bus.o_word_count !== 11'd0 ||
          bus.o_cpu_stall !== 1'b0 || wr_data.size() != 0) begin
         failures++;
         $display("FAIL reset_mid_load: busy=%0b done=%0b count=%0d stall=%0b writes=%0d, expected 0 0 0 0 0",
                  bus.o_busy, bus.o_load_done, bus.o_word_count, bus.o_cpu_stall, wr_data.size());
      end
      w = rand_word();
      stream.delete();
      push_word(w); push_word(HALT);
      start_load();
      send_stream(0, stream.size() - 1, 2);
      wait_done();
      checks++;
      if (wr_data.size() < 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== w) begin
         failures++;
         $display("FAIL reset_mid_reload: writes=%0d first=%h@%h, expected %h@000",
                  wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0,
                  (wr_addr.size() > 0) ? wr_addr[0] : 32'h0, w);
      end
   endtask

   task automatic test_random_loads();
      int n;
      int k;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 12);
         stream.delete();
         for (int j = 0; j < n; j++) push_word(rand_word());
         push_word(HALT);
         repeat ($urandom_range(1, 6)) stream.push_back(8'($urandom));
         build_expect();
         bus.i_cpu_addr = 12'h004;
         start_load();
         cpu_chk = (it % 2 == 1);
         send_stream(0, stream.size() - 1, it % 3);
         wait_done();
         cpu_chk = 1'b0;
         checks++;
         if (wr_data.size() != exp_data.size() || bus.o_word_count !== 11'(exp_data.size())) begin
            failures++;
            $display("FAIL rand_count[%0d]: writes=%0d count=%0d, expected %0d",
                     it, wr_data.size(), bus.o_word_count, exp_data.size());
         end
         for (int j = 0; j < exp_data.size() && j < wr_data.size(); j++) begin
            checks++;
            if (wr_addr[j] !== exp_addr[j] || wr_data[j] !== exp_data[j]) begin
               failures++;
               $display("FAIL rand_write[%0d.%0d]: %h@%h, expected %h@%h",
                        it, j, wr_data[j], wr_addr[j], exp_data[j], exp_addr[j]);
            end
         end
         k = $urandom_range(0, exp_data.size() - 1);
         bus.i_cpu_addr = exp_addr[k][11:0];
         #1;
         checks++;
         if (bus.o_cpu_instr !== exp_data[k] || bus.o_cpu_stall !== 1'b0 || bus.o_ram_addr !== exp_addr[k][11:0]) begin
            failures++;
            $display("FAIL rand_fetch[%0d]: instr=%h stall=%0b ram_addr=%h, expected %h 0 %h",
                     it, bus.o_cpu_instr, bus.o_cpu_stall, bus.o_ram_addr, exp_data[k], exp_addr[k][11:0]);
         end
      end
   endtask

   task automatic test_full();
      stream.delete();
      for (int j = 0; j < 1023; j++) push_word(rand_word());
      push_word(32'hDEAD_BEEF);
      for (int j = 0; j < 8; j++) stream.push_back(8'($urandom));
      build_expect();
      start_load();
      send_stream(0, stream.size() - 1, 1);
      wait_done();
      step(); step();
      checks++;
      if (wr_data.size() != 1024 || bus.o_word_count !== 11'd1024) begin
         failures++;
         $display("FAIL full_count: writes=%0d count=%0d, expected 1024 1024", wr_data.size(), bus.o_word_count);
      end else begin
         checks++;
         if (wr_addr[1023] !== 32'hFFC || wr_data[1023] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL full_last: %h@%h, expected deadbeef@ffc", wr_data[1023], wr_addr[1023]);
         end
      end
      for (int j = 0; j < exp_data.size() && j < wr_data.size(); j++) begin
         checks++;
         if (wr_addr[j] !== exp_addr[j] || wr_data[j] !== exp_data[j]) begin
            failures++;
            $display("FAIL full_write[%0d]: %h@%h, expected %h@%h", j, wr_data[j], wr_addr[j], exp_data[j], exp_addr[j]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = {16'hA5A5, 16'(i)};
      bus.i_load_start = 1'b0;
      bus.i_rx_byte    = 8'h00;
      bus.i_rx_valid   = 1'b0;
      bus.i_cpu_addr   = 12'h000;
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignored();
      test_reset_mid();
      test_random_loads();
      test_full();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_load_arbiter.md
IMEM_LOAD_ARBITER -- requirements
Module: imem_load_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: byte-address width of the shared instruction RAM.
REQ-002 Parameter DATA_WIDTH, default 8: byte width; the RAM word is DATA_WIDTH*4 bits.
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF: terminator word that ends a load.
REQ-004 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_load_start  in  1  one-cycle pulse that requests a program load.
REQ-007 i_rx_byte  in  DATA_WIDTH  byte from the UART receiver.
REQ-008 i_rx_valid  in  1  one-cycle strobe; i_rx_byte is valid while it is high.
REQ-009 i_cpu_addr  in  ADDR_WIDTH  CPU fetch byte address.
REQ-010 o_cpu_instr  out  DATA_WIDTH*4  instruction returned to the CPU.
REQ-011 o_cpu_stall  out  1  CPU shall freeze the PC while high.
REQ-012 o_ram_we  out  1  RAM write enable.
REQ-013 o_ram_addr  out  ADDR_WIDTH  RAM byte address.
REQ-014 o_ram_wdata  out  DATA_WIDTH*4  RAM write data.
REQ-015 i_ram_rdata  in  DATA_WIDTH*4  RAM asynchronous read data.
REQ-016 o_busy  out  1  high in LOAD and WRITE.
REQ-017 o_load_done  out  1  high while in DONE.
REQ-018 o_word_count  out  ADDR_WIDTH-1  number of words written by the current or last load, including the halt word.

Function
REQ-019 FSM states: IDLE, LOAD, WRITE, DONE.
REQ-020 IDLE or DONE with i_load_start=1 -> LOAD next cycle; write pointer, byte index and o_word_count cleared to 0; o_load_done drops.
REQ-021 i_load_start in LOAD or WRITE is ignored.
REQ-022 In LOAD, each i_rx_valid byte is shifted in big-endian (first byte -> bits [31:24]); byte index 0..3.
REQ-023 Fourth byte accepted -> WRITE next cycle.
REQ-024 WRITE lasts exactly one cycle: o_ram_we=1, o_ram_addr=write pointer, o_ram_wdata=assembled word; o_word_count increments by 1 at the end of the cycle.
REQ-025 Write pointer starts at 0 and advances by 4 after each write.
REQ-026 After WRITE -> DONE if the word equals HALT_WORD or the pointer equals 2**ADDR_WIDTH-4 (last word); otherwise -> LOAD.
REQ-027 An i_rx_valid byte during WRITE is captured as byte 0 of the next word if the next state is LOAD, otherwise discarded.
REQ-028 i_rx_valid in IDLE or DONE is ignored.
REQ-029 In IDLE and DONE: o_ram_addr=i_cpu_addr, o_cpu_instr=i_ram_rdata (combinational, zero latency), o_cpu_stall=0, o_ram_we=0.
REQ-030 In LOAD and WRITE: o_cpu_stall=1, o_cpu_instr=32'h0000_0000 (NOP), i_cpu_addr ignored.
REQ-031 o_ram_we is high only in WRITE; no other cycle writes the RAM.

Reset
REQ-032 i_reset=1 at a clock edge forces IDLE from any state, including mid-word and in WRITE.
REQ-033 Reset values: write pointer 0, byte index 0, assembly register 0, o_word_count 0, o_load_done 0, o_busy 0, o_ram_we 0, o_cpu_stall 0.
REQ-034 Reset does not clear RAM contents; a partial load remains in memory.

Structure
REQ-035 The FSM state encoding, the default HALT_WORD and the NOP constant are defined in the shared package imem_pkg.
REQ-036 Byte assembly (shift register plus byte index) is a sub-module, byte_to_word_packer, with ports i_clk, i_reset, i_clear, i_byte, i_valid, o_word, o_word_valid.
REQ-037 The RAM is instantiated outside the block; this block only drives the RAM ports.

Verification
REQ-038 Load start, bytes 12 34 56 78 then FF FF FF FF -> writes 0x12345678 @0x000 and 0xFFFFFFFF @0x004; DONE; o_word_count=2; CPU addr 0x000 reads 0x12345678 with stall=0.
REQ-039 Load of 1024 non-halt words -> last write 0xDEADBEEF @0xFFC; DONE with o_word_count=1024 with no 1025th write.
REQ-040 During a load, CPU addr 0x004 toggling -> o_cpu_stall=1, o_cpu_instr=0, o_ram_addr tracks the write pointer only.
REQ-041 Reset after 2 of 4 bytes -> IDLE, o_ram_we never asserted, o_word_count=0; a new load starts at 0x000.
REQ-042 i_load_start pulsed mid-load and i_rx_valid pulsed in DONE -> no state or counter change.
REQ-043 Byte strobed in the WRITE cycle of word 0 (0xAA) then 3 more bytes (BB CC DD) -> second write 0xAABBCCDD @0x004.
